apb_req_arbiter: RTL and testbench
==================================

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requester ports (2..8).
REQ-002 Parameter TIMEOUT_LIMIT, default 20, ACCESS cycles with apb_ready low before abort (1..255).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 The block SHALL provide the following ports, in this order:
- apb_clk  in  1  clock.
- apb_reset  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request, held until its req_done.
- req_addr  in  8*NUM_REQ  per-requester address; slice i = [8i+7:8i].
- req_data  in  32*NUM_REQ  per-requester write data.
- req_dir  in  NUM_REQ  1 = write, 0 = read.
- req_done  out  NUM_REQ  one-hot completion pulse.
- req_rdata  out  32  read data of the completed transfer.
- req_err  out  1  completion with slave error or timeout.
- apb_selx  out  1  APB select.
- apb_en  out  1  APB enable.
- apb_write  out  1  APB direction.
- apb_addr  out  8  APB address.
- apb_wdata  out  32  APB write data.
- apb_rdata  in  32  APB read data.
- apb_ready  in  1  APB ready.
- apb_slverr  in  1  APB slave error.

Function
REQ-005 The FSM SHALL have states IDLE, SETUP, ACCESS and DONE, with all outputs registered.
REQ-006 IDLE: if any req_valid is high at a clock edge, the FSM SHALL grant one requester by round-robin, latch that requester's addr, data and dir, and go to SETUP; otherwise it SHALL stay in IDLE.
REQ-007 Round-robin search SHALL start at (last_grant+1) mod NUM_REQ; after reset the pointer SHALL make requester 0 highest priority.
REQ-008 SETUP (exactly 1 cycle): apb_selx=1, apb_en=0, with apb_addr, apb_write and apb_wdata taken from the latched values; apb_wdata SHALL be 0 for reads.
REQ-009 ACCESS: apb_selx=1 and apb_en=1, with address, data and direction held stable.
REQ-010 ACCESS ends at the first edge with apb_ready=1, and the FSM goes to DONE.
REQ-011 On that edge, req_err SHALL take the value of apb_slverr, and req_rdata SHALL capture apb_rdata for a read or be 0 for a write.
REQ-012 An 8-bit timeout counter SHALL clear on SETUP and increment on each ACCESS cycle with apb_ready=0.
REQ-013 When the timeout counter reaches TIMEOUT_LIMIT, the FSM SHALL go to DONE with req_err=1 and req_rdata=0.
REQ-014 If apb_ready=1 on the same cycle the limit is reached, ready SHALL win and the transfer is not a timeout.
REQ-015 DONE (exactly 1 cycle): req_done[grant]=1, req_rdata and req_err valid, apb_selx=0, apb_en=0; the FSM then returns to IDLE.
REQ-016 In every state other than DONE, req_done, req_rdata and req_err SHALL be 0.
REQ-017 Latency with a zero-wait slave: valid seen at edge k gives SETUP during k..k+1, ACCESS during k+1..k+2, and DONE during k+2..k+3.
REQ-018 A requester SHALL drop req_valid in the cycle after its req_done; if valid is still high at the next IDLE, it is a new request.
REQ-019 Deasserting req_valid mid-transfer SHALL NOT abort the transfer; the transfer completes and req_done still pulses.
REQ-020 Changes to req_addr, req_data or req_dir after the grant SHALL be ignored until the next grant.

Reset
REQ-021 apb_reset=1 SHALL immediately force: state=IDLE; all APB outputs 0; req_done, req_rdata and req_err 0; timeout counter 0; round-robin pointer to requester 0.
REQ-022 Reset asserted mid-transfer SHALL drop the transfer with no req_done.

Structure
REQ-023 The shared package apb_pkg SHALL hold the state typedef (IDLE/SETUP/ACCESS/DONE) and the constants APB_ADDR_W=8 and APB_DATA_W=32.
REQ-024 Round-robin selection SHALL be a separate combinational sub-module, apb_rr_picker, with inputs req_valid and last_grant and outputs grant_idx and grant_any.

Verification
REQ-025 Single write: req0 write addr 4, data 10, ready=1 immediately -> SETUP then ACCESS, apb_wdata=10, req_done[0] pulses 3 cycles after valid, req_err=0.
REQ-026 Read-back: req1 read addr 4, slave returns 10 -> req_rdata=10 exactly in the req_done[1] cycle, and 0 afterwards.
REQ-027 Contention: req0 through req3 all valid at once, each dropping valid after its done -> grant order 0,1,2,3; after re-raising, order continues 0,1,2,3 with no starvation.
REQ-028 Timeout: ready held low, TIMEOUT_LIMIT=20 -> 20 ACCESS cycles, then DONE with req_err=1 and req_rdata=0.
REQ-029 Slave error plus boundary: slverr=1 with ready on access cycle 2 -> req_err=1; ready on exactly the 20th cycle -> req_err equals slverr (0), not a timeout.
REQ-030 Reset mid-ACCESS -> apb_selx and apb_en drop asynchronously, no req_done, and the next grant goes to req0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and widths for the APB request arbiter.
// Holds the bus FSM state encoding and address/data widths.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } apb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin picker.
// Searches from last_grant+1 upward, wrapping at NUM_REQ.
module apb_rr_picker
  import apb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  int j;

  // Walk farthest-first so the nearest valid requester wins.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    j         = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = (int'(last_grant) + k) % NUM_REQ;
      if (req_valid[j]) begin
        grant_idx = IDX_W'(j);
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Multi-requester APB master with round-robin grant and timeout.
// All outputs are registered; reset drops any transfer in flight.
module apb_req_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int TIMEOUT_LIMIT = 20
) (
  input  logic                    apb_clk,
  input  logic                    apb_reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [8*NUM_REQ-1:0]    req_addr,
  input  logic [32*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]      req_dir,
  output logic [NUM_REQ-1:0]      req_done,
  output logic [APB_DATA_W-1:0]   req_rdata,
  output logic                    req_err,
  output logic                    apb_selx,
  output logic                    apb_en,
  output logic                    apb_write,
  output logic [APB_ADDR_W-1:0]   apb_addr,
  output logic [APB_DATA_W-1:0]   apb_wdata,
  input  logic [APB_DATA_W-1:0]   apb_rdata,
  input  logic                    apb_ready,
  input  logic                    apb_slverr
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_LIMIT);

  apb_state_e state_q, state_d;

  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  selx_q, selx_d;
  logic                  en_q, en_d;
  logic                  write_q, write_d;
  logic [APB_ADDR_W-1:0] addr_q, addr_d;
  logic [APB_DATA_W-1:0] wdata_q, wdata_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic [APB_DATA_W-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  apb_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_valid  (req_valid),
    .last_grant (last_q),
    .grant_idx  (pick_idx),
    .grant_any  (pick_any)
  );

  always_ff @(posedge apb_clk or posedge apb_reset) begin
    if (apb_reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      selx_q  <= 1'b0;
      en_q    <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      selx_q  <= selx_d;
      en_q    <= en_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    selx_d  = selx_q;
    en_d    = en_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = '0;
    rdata_d = '0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = SETUP;
          grant_d = pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
          selx_d  = 1'b1;
          en_d    = 1'b0;
          write_d = req_dir[pick_idx];
          addr_d  = req_addr[int'(pick_idx)*APB_ADDR_W +: APB_ADDR_W];
          wdata_d = req_dir[pick_idx]
                  ? req_data[int'(pick_idx)*APB_DATA_W +: APB_DATA_W]
                  : '0;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        en_d    = 1'b1;
        cnt_d   = '0;
      end
      ACCESS: begin
        // Ready on the limit cycle still completes normally.
        if (apb_ready || (cnt_q + 8'd1 == LIMIT)) begin
          state_d          = DONE;
          done_d[grant_q]  = 1'b1;
          err_d            = apb_ready ? apb_slverr : 1'b1;
          rdata_d          = (apb_ready && !write_q) ? apb_rdata : '0;
          cnt_d            = '0;
          selx_d           = 1'b0;
          en_d             = 1'b0;
          write_d          = 1'b0;
          addr_d           = '0;
          wdata_d          = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_done  = done_q;
  assign req_rdata = rdata_q;
  assign req_err   = err_q;
  assign apb_selx  = selx_q;
  assign apb_en    = en_q;
  assign apb_write = write_q;
  assign apb_addr  = addr_q;
  assign apb_wdata = wdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: transaction model plus directed
// scenarios with literal expectations.
module tb_apb_req_arbiter;

  localparam int N   = 4;
  localparam int LIM = 20;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    valid = '0;
  logic [8*N-1:0]  addr = '0;
  logic [32*N-1:0] data = '0;
  logic [N-1:0]    dir = '0;
  logic [N-1:0]    req_done;
  logic [31:0]     req_rdata;
  logic            req_err;
  logic            apb_selx, apb_en, apb_write;
  logic [7:0]      apb_addr;
  logic [31:0]     apb_wdata;
  logic [31:0]     s_rdata = '0;
  logic            s_ready = 1'b0;
  logic            s_err = 1'b0;

  apb_req_arbiter #(.NUM_REQ(N), .TIMEOUT_LIMIT(LIM)) dut (
    .apb_clk    (clk),
    .apb_reset  (rst),
    .req_valid  (valid),
    .req_addr   (addr),
    .req_data   (data),
    .req_dir    (dir),
    .req_done   (req_done),
    .req_rdata  (req_rdata),
    .req_err    (req_err),
    .apb_selx   (apb_selx),
    .apb_en     (apb_en),
    .apb_write  (apb_write),
    .apb_addr   (apb_addr),
    .apb_wdata  (apb_wdata),
    .apb_rdata  (s_rdata),
    .apb_ready  (s_ready),
    .apb_slverr (s_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Transaction-level model: one transfer record at a time.
  int          ptr, idx, waitc, j;
  bit          busy, in_acc, in_done;
  logic        e_selx, e_en, e_write, e_err;
  logic [7:0]  e_addr;
  logic [31:0] e_wdata, e_rdata;
  logic [N-1:0] e_done;

  task automatic finish_xfer(input logic er, input logic [31:0] rd);
    e_done      = '0;
    e_done[idx] = 1'b1;
    e_rdata     = rd;
    e_err       = er;
    e_selx      = 1'b0;
    e_en        = 1'b0;
    e_write     = 1'b0;
    e_addr      = '0;
    e_wdata     = '0;
    busy        = 1'b0;
    in_acc      = 1'b0;
    in_done     = 1'b1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr = N - 1; busy = 0; in_acc = 0; in_done = 0;
      idx = 0; waitc = 0;
      e_selx = 0; e_en = 0; e_write = 0; e_err = 0;
      e_addr = '0; e_wdata = '0; e_rdata = '0; e_done = '0;
    end else if (in_done) begin
      in_done = 0; e_done = '0; e_rdata = '0; e_err = 0;
    end else if (!busy) begin
      for (int k = 1; k <= N; k++) begin
        j = (ptr + k) % N;
        if (!busy && valid[j]) begin
          busy = 1; in_acc = 0; ptr = j; idx = j;
          e_selx = 1; e_en = 0;
          e_write = dir[j];
          e_addr = addr[8*j +: 8];
          e_wdata = dir[j] ? data[32*j +: 32] : 32'h0;
        end
      end
    end else if (!in_acc) begin
      in_acc = 1; e_en = 1; waitc = 0;
    end else if (s_ready) begin
      finish_xfer(s_err, e_write ? 32'h0 : s_rdata);
    end else begin
      waitc++;
      if (waitc == LIM) finish_xfer(1'b1, 32'h0);
    end
  end

  always @(negedge clk) begin
    chk("selx", apb_selx, e_selx);
    chk("en", apb_en, e_en);
    chk("write", apb_write, e_write);
    chk("addr", apb_addr, e_addr);
    chk("wdata", apb_wdata, e_wdata);
    chk("done", req_done, e_done);
    chk("rdata", req_rdata, e_rdata);
    chk("err", req_err, e_err);
  end

  task automatic run_xfer(
    input int r, input bit wr, input logic [7:0] a,
    input logic [31:0] d, input int rdy_on, input bit serr,
    input logic [31:0] rd, input bit mess,
    output logic [31:0] got_rd, output logic got_err,
    output logic [31:0] got_wd, output int acc, output int lat);
    bit seen;
    bit setup_seen;
    @(negedge clk);
    addr[8*r +: 8] = a;
    data[32*r +: 32] = d;
    dir[r] = wr;
    valid[r] = 1'b1;
    s_ready = 0; s_err = serr; s_rdata = rd;
    acc = 0; lat = 0; seen = 0; setup_seen = 0;
    got_rd = '0; got_err = 0; got_wd = '0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (req_done != '0) begin
        seen = 1;
        chk("done_idx", req_done, 64'(1 << r));
        got_rd = req_rdata;
        got_err = req_err;
        valid[r] = 1'b0;
        s_ready = 0;
      end else begin
        if (apb_selx && !apb_en && !setup_seen) begin
          setup_seen = 1;
          got_wd = apb_wdata;
        end
        if (apb_en) begin
          acc++;
          s_ready = (acc == rdy_on);
        end
        if (mess && apb_selx) begin
          valid[r] = 1'b0;
          addr[8*r +: 8] = ~a;
          data[32*r +: 32] = ~d;
          dir[r] = ~wr;
        end
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL wait_done req%0d got none want pulse", r);
    end
    @(negedge clk);
    chk("rdata_after", req_rdata, 0);
  endtask

  logic [31:0] g_rd, g_wd;
  logic        g_err;
  int          g_acc, g_lat;
  int          order[$];
  bit          hit;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_selx", apb_selx, 0);
    chk("rst_done", req_done, 0);
    rst = 0;

    run_xfer(0, 1, 8'd4, 32'd10, 1, 0, 32'h0, 0,
             g_rd, g_err, g_wd, g_acc, g_lat);
    chk("wr_lat", g_lat, 3);
    chk("wr_acc", g_acc, 1);
    chk("wr_err", g_err, 0);
    chk("wr_wdata", g_wd, 10);

    run_xfer(1, 0, 8'd4, 32'h77, 1, 0, 32'd10, 0,
             g_rd, g_err, g_wd, g_acc, g_lat);
    chk("rd_rdata", g_rd, 10);
    chk("rd_wdata", g_wd, 0);
    chk("rd_err", g_err, 0);

    run_xfer(2, 0, 8'h20, 32'h0, 0, 0, 32'hdead, 0,
             g_rd, g_err, g_wd, g_acc, g_lat);
    chk("to_acc", g_acc, 20);
    chk("to_err", g_err, 1);
    chk("to_rdata", g_rd, 0);

    run_xfer(3, 1, 8'h33, 32'h1234, 2, 1, 32'h0, 1,
             g_rd, g_err, g_wd, g_acc, g_lat);
    chk("se_err", g_err, 1);
    chk("se_acc", g_acc, 2);

    run_xfer(0, 0, 8'h40, 32'h0, 20, 0, 32'h55, 0,
             g_rd, g_err, g_wd, g_acc, g_lat);
    chk("bnd_err", g_err, 0);
    chk("bnd_acc", g_acc, 20);
    chk("bnd_rdata", g_rd, 32'h55);

    // Reset in the middle of an access phase.
    @(negedge clk);
    dir[2] = 1; addr[16 +: 8] = 8'h60; valid[2] = 1; s_ready = 0;
    hit = 0;
    for (int c = 0; c < 10 && !hit; c++) begin
      @(negedge clk);
      if (apb_en) hit = 1;
    end
    chk("mid_en_seen", hit, 1);
    #2 rst = 1;
    #1;
    chk("mid_selx", apb_selx, 0);
    chk("mid_en", apb_en, 0);
    valid[2] = 0;
    @(negedge clk);
    chk("mid_nodone", req_done, 0);
    rst = 0;
    valid[0] = 1; valid[2] = 1; dir[0] = 0; dir[2] = 0;
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (req_done != '0) begin
        hit = 1;
        chk("post_rst_grant", req_done, 4'b0001);
        valid = '0; s_ready = 0;
      end else if (apb_en) s_ready = 1;
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL post_rst_wait got none want pulse");
    end
    repeat (3) @(negedge clk);

    // Contention across two rounds after a fresh reset.
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < N; i++) begin
      addr[8*i +: 8] = 8'(16 * i);
      data[32*i +: 32] = 32'h100 + 32'(i);
      dir[i] = 1'b1;
    end
    valid = '1;
    for (int c = 0; c < 80 && order.size() < 2*N; c++) begin
      @(negedge clk);
      if (req_done != '0) begin
        for (int i = 0; i < N; i++)
          if (req_done[i]) begin
            order.push_back(i);
            valid[i] = 1'b0;
          end
        s_ready = 0;
      end else begin
        if (apb_en) s_ready = 1;
        if (order.size() == N && valid == '0) valid = '1;
      end
    end
    chk("rr_count", order.size(), 2*N);
    for (int i = 0; i < order.size(); i++)
      chk($sformatf("rr_order%0d", i), order[i], i % N);
    valid = '0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got hang want finish");
    $fatal(1);
  end

endmodule
